// File: rtl/logic_unit_arbiter_if.sv
// rtl/logic_unit_arbiter_if.sv - requester/result bus of the shared logic unit arbiter
interface logic_unit_arbiter_if #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 16
);
  localparam int IDW = $clog2(NREQ);

  logic [NREQ-1:0]       req;
  logic [2*NREQ-1:0]     op;
  logic [WIDTH*NREQ-1:0] a;
  logic [WIDTH*NREQ-1:0] b;
  logic [NREQ-1:0]       grant;
  logic                  res_valid;
  logic [IDW-1:0]        res_id;
  logic [WIDTH-1:0]      res_data;
  logic                  res_ready;

  // requesters and the result consumer
  modport master (
    output req, op, a, b, res_ready,
    input  grant, res_valid, res_id, res_data
  );

  // the arbiter itself
  modport slave (
    input  req, op, a, b, res_ready,
    output grant, res_valid, res_id, res_data
  );
endinterface

// File: rtl/logic_unit_arbiter.sv
// rtl/logic_unit_arbiter.sv - round-robin shared registered AND/OR/XOR/NOT unit
module logic_unit_arbiter #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  logic_unit_arbiter_if.slave  bus
);
  localparam int IDW = $clog2(NREQ);

  typedef enum logic [1:0] {IDLE, EXEC, HOLD} state_t;

  state_t            state_q, state_d;
  logic [IDW-1:0]    ptr_q, ptr_d;
  logic [NREQ-1:0]   grant_q, grant_d;
  logic              res_valid_q, res_valid_d;
  logic [IDW-1:0]    res_id_q, res_id_d;
  logic [WIDTH-1:0]  res_data_q, res_data_d;
  logic [1:0]        op_q, op_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  b_q, b_d;

  logic              found;
  logic [IDW-1:0]    pick;
  int                idx;

  function automatic logic [WIDTH-1:0] logic_op(input logic [1:0] opc,
                                                input logic [WIDTH-1:0] x,
                                                input logic [WIDTH-1:0] y);
    case (opc)
      2'b00:   logic_op = x & y;
      2'b01:   logic_op = x | y;
      2'b10:   logic_op = x ^ y;
      default: logic_op = ~x;
    endcase
  endfunction

  // round-robin search: first pending requester starting at ptr, wrapping
  always_comb begin
    found = 1'b0;
    pick  = '0;
    idx   = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(ptr_q) + k) % NREQ;
      if (!found && bus.req[idx]) begin
        found = 1'b1;
        pick  = idx[IDW-1:0];
      end
    end
  end

  // next-state and registered-output computation
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    grant_d     = '0;
    res_valid_d = res_valid_q;
    res_id_d    = res_id_q;
    res_data_d  = res_data_q;
    op_d        = op_q;
    a_d         = a_q;
    b_d         = b_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          grant_d[pick] = 1'b1;
          res_id_d      = pick;
          op_d          = bus.op[2*pick +: 2];
          a_d           = bus.a[WIDTH*pick +: WIDTH];
          b_d           = bus.b[WIDTH*pick +: WIDTH];
          state_d       = EXEC;
        end
      end
      EXEC: begin
        res_data_d  = logic_op(op_q, a_q, b_q);
        res_valid_d = 1'b1;
        state_d     = HOLD;
      end
      HOLD: begin
        if (bus.res_ready) begin
          res_valid_d = 1'b0;
          ptr_d       = (res_id_q == IDW'(NREQ-1)) ? '0 : res_id_q + 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // state and datapath registers; reset overrides everything
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      grant_q     <= '0;
      res_valid_q <= 1'b0;
      res_id_q    <= '0;
      res_data_q  <= '0;
      op_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      grant_q     <= grant_d;
      res_valid_q <= res_valid_d;
      res_id_q    <= res_id_d;
      res_data_q  <= res_data_d;
      op_q        <= op_d;
      a_q         <= a_d;
      b_q         <= b_d;
    end
  end

  assign bus.grant     = grant_q;
  assign bus.res_valid = res_valid_q;
  assign bus.res_id    = res_id_q;
  assign bus.res_data  = res_data_q;
endmodule
